pipe_pc_ctrl: RTL
=================

# pipe_pc_ctrl

PC-control and hazard unit for the 5-stage pipeline. Every cycle it decides how the PC register advances (PCWrite, PCSrc), and when the IF/ID and ID/EX pipeline registers are held or flushed. It sits between the ID/EX decode and compare logic and the PC register, and drives every PC-select and stall input the PC register has. Its decision sources are branch resolution, jumps, illegal-opcode and interrupt entry, load-use hazards and instruction-memory wait.

## Interface
Parameters:
- LOAD_STALL, 1: bubbles inserted per load-use hazard. Legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- imem_ready  in  1  instruction memory returned the word for the current PC.
- pc_super  in  1  PC[31] of the ID-stage instruction (kernel mode).
- id_valid  in  1  IF/ID holds a real instruction, not a bubble.
- id_jump  in  1  ID instruction is J/JAL.
- id_jr  in  1  ID instruction is JR/JALR.
- id_illop  in  1  ID opcode is undefined.
- id_rs, id_rt  in  5 each  ID source register numbers.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  5  EX load destination.
- ex_branch_taken  in  1  EX branch resolved taken (ALUOut[0]).
- irq  in  1  external interrupt request, level, asynchronous.
- PCWrite  out  1  PC register load enable.
- PCSrc  out  3  next-PC select: 000 PC+4, 001 branch, 010 jump, 011 register, 100 ILLOP, 101 XADR.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID becomes a bubble.
- idex_flush  out  1  ID/EX becomes a bubble.
- epc_write  out  1  capture the ID-stage PC into EPC.
- irq_ack  out  1  one-cycle pulse when the interrupt is taken.

## Operation
- **States.**
  - RUN is the normal state.
  - STALL inserts load-use bubbles and uses a 2-bit down-counter.
  - WAIT holds the front end while imem_ready is low.
- **Outputs.** All outputs are combinational from state and inputs. While reset is low, every output is 0 and PCSrc is 000.
- **Decision priority.** In RUN and WAIT the first matching rule applies:
  1. ex_branch_taken: PCSrc=001, PCWrite=1, ifid_flush=1, idex_flush=1. Next state RUN. This applies in every state, including WAIT and STALL.
  2. id_valid & id_illop: PCSrc=100, PCWrite=1, ifid_flush=1, idex_flush=1, epc_write=1. Next state RUN.
  3. id_valid & irq_pend & !pc_super: PCSrc=101, PCWrite=1, flush both registers, epc_write=1, irq_ack=1, clear irq_pend.
  4. Load-use hazard: id_valid & ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). PCWrite=0, ifid_write=0, idex_flush=1. Load counter with LOAD_STALL-1. Next state is STALL if the count is nonzero, else RUN.
  5. id_valid & (id_jump | id_jr): PCSrc = 010 or 011 respectively, PCWrite=1, ifid_flush=1. There is no delay slot.
  6. !imem_ready: PCWrite=0, ifid_write=0, idex_flush=1. Next state WAIT.
  7. Otherwise: PCSrc=000, PCWrite=1, ifid_write=1.
- **STALL.**
  - Outputs are as in rule 4; the counter decrements each cycle.
  - When the counter reaches 0, the next state is RUN.
  - Rules 1–3 preempt STALL and clear the counter.
- **WAIT.** Rules 1–7 are evaluated; the next state is RUN on the first cycle imem_ready=1.
- **Interrupts.**
  - irq passes through a 2-flop synchronizer.
  - A synchronized 1 sets irq_pend; irq_pend stays set until rule 3 fires.
  - A deferred interrupt (kernel mode, branch, or illop) stays pending.

## Timing
- All decisions take zero cycles: they act on the same clock edge.
- irq-to-pend latency is 3 edges.
- The load-use penalty is exactly LOAD_STALL cycles.
- Reset values:
  - State RUN, counter 0.
  - Synchronizer 00, irq_pend 0.
- Reset deasserted mid-STALL or mid-WAIT restarts in RUN with no pending interrupt.
- When the branch and the load-use hazard fire in the same cycle, the branch wins and no bubble count remains.

## Configuration
- PIPE_IRQ_EN defined: synchronizer, irq_pend and rule 3 are present.
- PIPE_IRQ_EN undefined: irq is ignored; irq_ack and the XADR select are never produced. epc_write fires only on illop.

## Structure
- Shared package pipe_pkg holds:
  - the PCSrc encodings: PCSRC_PLUS4, PCSRC_BRANCH, PCSRC_JUMP, PCSRC_JR, PCSRC_ILLOP, PCSRC_XADR;
  - the ILLOP and XADR vectors, 32'h8000_0004 and 32'h8000_0008;
  - the state type.
- One sub-module is natural: pipe_irq_sync, containing the synchronizer plus the pending flag.

## Test plan
- Load r5 in EX, ID reads rs=5 with LOAD_STALL=2 → PCWrite=0 and idex_flush=1 for 2 cycles, then PCSrc=000.
- ex_branch_taken=1 together with id_illop=1 → PCSrc=001, both flushes asserted, epc_write=0.
- irq pulse while pc_super=0 → irq_ack on the 3rd or 4th edge with PCSrc=101 and epc_write=1. With pc_super=1 the interrupt is held pending until pc_super drops.
- imem_ready low for 4 cycles → PCWrite=0 for 4 cycles. A taken branch arriving during the wait still gives PCWrite=1 and PCSrc=001.
- id_jr=1 with no hazard → PCSrc=011 and ifid_flush=1 in the same cycle.
- reset low in STALL → outputs 0 immediately; after release, state is RUN and PCSrc=000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline PC-control unit: PC-select codes,
// exception vectors and the control FSM state type.
package pipe_pkg;

    localparam logic [2:0] PCSRC_PLUS4  = 3'b000;
    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_JR     = 3'b011;
    localparam logic [2:0] PCSRC_ILLOP  = 3'b100;
    localparam logic [2:0] PCSRC_XADR   = 3'b101;

    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_irq_sync.sv
// Two-flop synchronizer for the asynchronous irq line plus the sticky pending
// flag that holds a request until the control unit takes it.
module pipe_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic take,
    output logic pend
);

    logic [1:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b00;
            pend <= 1'b0;
        end else begin
            sync <= {sync[0], irq};
            pend <= sync[1] | (pend & ~take);
        end
    end

endmodule

// File: rtl/pipe_pc_ctrl.sv
// PC-control and hazard unit: selects the next PC and holds/flushes IF/ID and
// ID/EX. Interrupt entry is built only when PIPE_IRQ_EN is defined.
module pipe_pc_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_ready,
    input  logic       pc_super,
    input  logic       id_valid,
    input  logic       id_jump,
    input  logic       id_jr,
    input  logic       id_illop,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       irq,
    output logic       PCWrite,
    output logic [2:0] PCSrc,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       epc_write,
    output logic       irq_ack
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       irq_pend;
    logic       irq_hit;
    logic       load_use;

`ifdef PIPE_IRQ_EN
    pipe_irq_sync u_irq_sync (
        .clk  (clk),
        .reset(reset),
        .irq  (irq),
        .take (irq_ack),
        .pend (irq_pend)
    );
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_pend   = 1'b0;
`endif

    assign irq_hit  = id_valid & irq_pend & ~pc_super;
    assign load_use = id_valid & ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // NOTE: every signal written here gets a default first, so no path
    // through the priority chain can leave one unassigned and infer a latch.
    always_comb begin
        PCWrite    = 1'b0;
        PCSrc      = PCSRC_PLUS4;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        epc_write  = 1'b0;
        irq_ack    = 1'b0;
        state_nxt  = ST_RUN;
        cnt_nxt    = 2'd0;

        if (ex_branch_taken) begin
            PCSrc      = PCSRC_BRANCH;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (id_valid && id_illop) begin
            PCSrc      = PCSRC_ILLOP;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            epc_write  = 1'b1;
        end else if (irq_hit) begin
            PCSrc      = PCSRC_XADR;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            epc_write  = 1'b1;
            irq_ack    = 1'b1;
        end else if (state == ST_STALL) begin
            // Remaining bubbles are forced regardless of the current hazard inputs.
            idex_flush = 1'b1;
            if (cnt > 2'd1) begin
                cnt_nxt   = cnt - 2'd1;
                state_nxt = ST_STALL;
            end
        end else if (load_use) begin
            idex_flush = 1'b1;
            cnt_nxt    = STALL_INIT;
            state_nxt  = (STALL_INIT != 2'd0) ? ST_STALL : ST_RUN;
        end else if (id_valid && (id_jump || id_jr)) begin
            PCSrc      = id_jump ? PCSRC_JUMP : PCSRC_JR;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
        end else if (!imem_ready) begin
            idex_flush = 1'b1;
            state_nxt  = ST_WAIT;
        end else begin
            PCWrite    = 1'b1;
            ifid_write = 1'b1;
        end

        // Outputs are forced quiet for as long as reset is held low.
        if (!reset) begin
            PCWrite    = 1'b0;
            PCSrc      = PCSRC_PLUS4;
            ifid_write = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            epc_write  = 1'b0;
            irq_ack    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
